// File: rtl/jump_motion.sv
// Player vertical-motion engine: turns conditioned up/down button levels into a
// jump/duck state machine with a saturating height coordinate.
module jump_motion #(
   parameter int Y_W       = 8,
   parameter int MAX_H     = 100,
   parameter int RISE_STEP = 2,
   parameter int FALL_STEP = 2,
   parameter int TICK_DIV  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           con_up,
   input  logic           con_down,
   output logic [Y_W-1:0] y,
   output logic [1:0]     state,
   output logic           jumping,
   output logic           ducking,
   output logic           land
);

   typedef enum logic [1:0] {
      GROUND = 2'd0,
      RISE   = 2'd1,
      FALL   = 2'd2,
      DUCK   = 2'd3
   } state_t;

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   // Height arithmetic carries one extra bit so sums and compares never wrap.
   localparam logic [Y_W:0] MAX_X  = (Y_W+1)'(MAX_H);
   localparam logic [Y_W:0] RISE_X = (Y_W+1)'(RISE_STEP);
   localparam logic [Y_W:0] FALL_X = (Y_W+1)'(FALL_STEP);
   localparam logic [Y_W:0] FAST_X = (Y_W+1)'(2 * FALL_STEP);

   state_t           cur;
   logic [Y_W-1:0]   y_r;
   logic [CNT_W-1:0] cnt;
   logic             con_up_q;

   logic             up_rise;
   logic             tick;
   logic [Y_W:0]     y_ext;
   logic [Y_W:0]     rise_sum;
   logic [Y_W:0]     fall_sel;
   logic [Y_W-1:0]   fall_diff;

   always_comb begin
      up_rise   = con_up & ~con_up_q;
      tick      = (cnt == CNT_LAST);
      y_ext     = {1'b0, y_r};
      rise_sum  = y_ext + RISE_X;
      fall_sel  = con_down ? FAST_X : FALL_X;
      fall_diff = y_r - fall_sel[Y_W-1:0];
   end

   // Single registered FSM; land is cleared every cycle unless a landing happens.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur      <= GROUND;
         y_r      <= '0;
         land     <= 1'b0;
         cnt      <= '0;
         con_up_q <= 1'b0;
      end else begin
         con_up_q <= con_up;
         cnt      <= tick ? '0 : cnt + 1'b1;
         land     <= 1'b0;
         case (cur)
            GROUND: begin
               y_r <= '0;
               if (up_rise)
                  cur <= RISE;
               else if (con_down)
                  cur <= DUCK;
            end
            RISE: begin
               // A down press aborts the rise immediately, ahead of any tick.
               if (con_down)
                  cur <= FALL;
               else if (tick) begin
                  if (rise_sum >= MAX_X) begin
                     y_r <= MAX_X[Y_W-1:0];
                     cur <= FALL;
                  end else begin
                     y_r <= rise_sum[Y_W-1:0];
                  end
               end
            end
            FALL: begin
               if (tick) begin
                  if (y_ext <= fall_sel) begin
                     y_r  <= '0;
                     cur  <= GROUND;
                     land <= 1'b1;
                  end else begin
                     y_r <= fall_diff;
                  end
               end
            end
            DUCK: begin
               y_r <= '0;
               if (up_rise)
                  cur <= RISE;
               else if (!con_down)
                  cur <= GROUND;
            end
            default: begin
               cur <= GROUND;
               y_r <= '0;
            end
         endcase
      end
   end

   assign y       = y_r;
   assign state   = cur;
   assign jumping = (cur == RISE) || (cur == FALL);
   assign ducking = (cur == DUCK);

endmodule

// File: doc/jump_motion.md
# jump_motion

Player vertical-motion engine for the monster-jump game. Consumes the conditioned button levels `con_up` / `con_down` from the input-conditioning block and turns them into a jump/duck state machine with a height coordinate `y`. Feeds the renderer and collision logic. It is the receiving end of the `con_up` / `con_down` interface.

## Interface

Parameters:
- `Y_W`, 8: width of `y`.
- `MAX_H`, 100: jump apex height; must satisfy 1 ≤ `MAX_H` < 2^`Y_W`.
- `RISE_STEP`, 2: height gained per motion tick while rising; ≥ 1.
- `FALL_STEP`, 2: height lost per motion tick while falling; ≥ 1. Fast fall uses 2×`FALL_STEP`.
- `TICK_DIV`, 4: clocks per motion tick; ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `con_up`  in  1  conditioned jump request (level, may pulse).
- `con_down`  in  1  conditioned duck / fast-fall request (level).
- `y`  out  `Y_W`  current height above ground; 0 = on ground.
- `state`  out  2  GROUND=0, RISE=1, FALL=2, DUCK=3.
- `jumping`  out  1  high in RISE or FALL.
- `ducking`  out  1  high in DUCK.
- `land`  out  1  single-cycle pulse on the FALL→GROUND transition.

## Operation

- Reset (`rst_n`=0 at a clock edge): `state`=GROUND, `y`=0, `land`=0, tick counter=0, `con_up_q`=0. Reset overrides all other events, including mid-jump; no `land` pulse on reset.
- Edge detect: `con_up_q` registers `con_up` every cycle. `up_rise` = `con_up` & ~`con_up_q` (combinational). Only rising edges start a jump. A held `con_up` yields one jump.
- Tick: counter runs 0..`TICK_DIV`-1 and wraps, free-running from reset. `tick`=1 when counter = `TICK_DIV`-1. With `TICK_DIV`=1, `tick` is always 1.
- GROUND: `up_rise` → RISE. Otherwise `con_down`=1 → DUCK. Otherwise stay. `y` is held at 0. `up_rise` has priority over `con_down`.
- RISE:
  - `con_down`=1 → FALL on the next edge; `y` is unchanged that cycle. This takes priority over `tick`.
  - Otherwise, on `tick`: if `y`+`RISE_STEP` ≥ `MAX_H`, then `y`=`MAX_H` and state → FALL. Else `y` += `RISE_STEP`.
  - `up_rise` is ignored (no double jump).
- FALL:
  - On `tick`, step = 2×`FALL_STEP` if `con_down`=1, else `FALL_STEP`.
  - If `y` ≤ step: `y`=0, state → GROUND, `land`=1 for exactly that next cycle. Else `y` -= step.
  - `up_rise` is ignored.
- DUCK: `up_rise` → RISE, with priority. Else `con_down`=0 → GROUND. Else stay. `y`=0.
- Arithmetic: sums and compares are done in `Y_W`+1 bits; `y` never wraps and never exceeds `MAX_H`.
- `jumping` and `ducking` decode directly from the `state` register (no extra latency). `land` is registered.

## Timing

- Jump start: `up_rise` true before edge n → `state`=RISE after edge n (1-cycle latency). The first height change happens on the first `tick` after that.
- Apex: `y`=`MAX_H` and `state`=FALL appear after the same edge.
- Landing: `y`=0, `state`=GROUND and `land`=1 appear after the same edge. `land` returns to 0 after the next edge.
- An `up_rise` during the `land` cycle (GROUND) starts a new jump on that edge.
- Default timing: full rise = 50 ticks = 200 clk; full fall = 50 ticks = 200 clk.

## Test plan

- **Reset:** hold `rst_n`=0 for 3 cycles while toggling `con_up`/`con_down` → `y`=0, `state`=0, `land`=0 throughout. Release → GROUND.
- **Full jump:** 1-cycle `con_up` pulse → `state`=1 next cycle. `y` increments by 2 every 4 clk and reaches 100 after 50 ticks with `state`=2. Then `y` decrements by 2 per tick. After 50 more ticks, `y`=0, `state`=0, and `land` is high for exactly 1 cycle.
- **Fast fall:** during RISE at `y`=40, assert `con_down` → `state`=2 next cycle with `y`=40. `y` then falls by 4 per tick and lands after 10 ticks.
- **Duck:** `con_down`=1 in GROUND → `state`=3, `ducking`=1. A `con_up` edge while ducking → RISE. Separate run: release `con_down` → GROUND next cycle.
- **Held button:** `con_up` held high for 1000 cycles → exactly one `land` pulse. Then `state` stays GROUND until `con_up` falls and rises again.
- **Reset mid-fall:** `rst_n`=0 for 1 cycle at `y`=60 in FALL → `y`=0, `state`=0, `land`=0 after that edge.
